// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary decoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_MAX     = 9;

  // Smallest binary width that can hold every value of a digits-wide BCD word,
  // i.e. the smallest w with 2^w >= 10^digits.
  function automatic int min_bin_width(input int digits);
    longint unsigned pow10;
    pow10 = 1;
    for (int i = 0; i < digits; i++) pow10 = pow10 * 10;
    for (int w = 0; w < 63; w++) begin
      if ((64'd1 << w) >= pow10) return w;
    end
    return 63;
  endfunction

endpackage

// File: rtl/bcd_to_bin_mac10.sv
// Purpose: one decimal multiply-accumulate step, acc*10 + digit, truncated to BIN_W.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: acc (running value), digit (next BCD nibble), acc_next (updated value),
//        digit_err (nibble outside 0..9; raw value is still accumulated).
module bcd_mac10
  import bcd_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic [BIN_W-1:0]       acc,
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BIN_W-1:0]       acc_next,
  output logic                   digit_err
);

  // x*10 as x*8 + x*2 keeps this to two adders instead of a multiplier.
  assign acc_next  = (acc << 3) + (acc << 1) + BIN_W'(digit);
  assign digit_err = (digit > BCD_DIGIT_W'(BCD_MAX));

endmodule

// File: rtl/bcd_to_bin.sv
// Purpose: converts a packed multi-digit BCD word to binary, one digit per clock, MSD first.
// Latency: out_valid rises DIGITS cycles after the accept edge; one word per DIGITS+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
// Ports: sys_clk/sys_reset (async active-high), in_valid/in_ready/bcd_in (input word),
//        out_valid/out_ready/bin_out/out_err (result), busy (conversion in progress).
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                          sys_clk,
  input  logic                          sys_reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BIN_W-1:0]              bin_out,
  output logic                          out_err,
  output logic                          busy
);

  localparam int WORD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $fatal(1, "bcd_to_bin: DIGITS=%0d outside 1..8", DIGITS);
  end
  if (BIN_W < min_bin_width(DIGITS)) begin : g_bad_width
    $fatal(1, "bcd_to_bin: BIN_W=%0d too narrow for %0d digits", BIN_W, DIGITS);
  end

  state_t             state;
  state_t             state_nxt;
  logic [WORD_W-1:0]  shreg;
  logic [CNT_W-1:0]   cnt;
  logic [BIN_W-1:0]   acc;
  logic               err;

  logic               first_step;
  logic [BIN_W-1:0]   mac_acc;
  logic [BIN_W-1:0]   mac_next;
  logic               mac_err;

  // Clearing of acc/err is folded into the first CONV step so that bin_out
  // keeps showing the previous result until that edge.
  assign first_step = (cnt == CNT_W'(DIGITS - 1));
  assign mac_acc    = first_step ? '0 : acc;

  bcd_mac10 #(
    .BIN_W (BIN_W)
  ) u_mac10 (
    .acc       (mac_acc),
    .digit     (shreg[WORD_W-1 -: BCD_DIGIT_W]),
    .acc_next  (mac_next),
    .digit_err (mac_err)
  );

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)      state_nxt = CONV;
      CONV:    if (cnt == '0)     state_nxt = DONE;
      DONE:    if (out_ready)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      shreg <= '0;
      cnt   <= '0;
      acc   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg <= bcd_in;
            cnt   <= CNT_W'(DIGITS - 1);
          end
        end
        CONV: begin
          acc   <= mac_next;
          err   <= (first_step ? 1'b0 : err) | mac_err;
          shreg <= shreg << BCD_DIGIT_W;
          cnt   <= cnt - CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake outputs depend on state only.
  assign in_ready  = (state == IDLE);
  assign busy      = (state == CONV);
  assign out_valid = (state == DONE);
  assign bin_out   = acc;
  assign out_err   = err;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin with a queue-based scoreboard.
module tb_bcd_to_bin;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int TMO    = 40;

  typedef struct packed {
    logic [BIN_W-1:0] bin;
    logic             err;
  } exp_t;

  logic                  sys_clk;
  logic                  sys_reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [BIN_W-1:0]      bin_out;
  logic                  out_err;
  logic                  busy;

  int   n_cmp;
  int   n_bad;
  int   cyc;
  int   acc_cyc;
  int   prev_acc;
  exp_t sb[$];
  exp_t junk;

  bcd_to_bin #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_reset (sys_reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .out_err   (out_err),
    .busy      (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Reference: decimal evaluation of the nibbles, MSD first, modulo 2^BIN_W.
  function automatic exp_t model(input logic [4*DIGITS-1:0] w);
    exp_t        r;
    int unsigned a;
    logic [3:0]  d;
    a     = 0;
    r.err = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = w[4*i +: 4];
      a = (a * 10 + int'(d)) % (1 << BIN_W);
      if (d > 4'd9) r.err = 1'b1;
    end
    r.bin = a[BIN_W-1:0];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a word and wait (bounded) for it to be accepted; returns #1 after the accept edge.
  task automatic send(input string tag, input logic [4*DIGITS-1:0] w, input bit keep_valid);
    bit done;
    done     = 1'b0;
    bcd_in   = w;
    in_valid = 1'b1;
    for (int i = 0; i < TMO && !done; i++) begin
      if (in_ready) done = 1'b1;
      @(posedge sys_clk);
      #1;
    end
    if (!done) chk({tag, "_accept_timeout"}, 0, 1);
    sb.push_back(model(w));
    prev_acc = acc_cyc;
    acc_cyc  = cyc;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  // Wait for out_valid, check latency and payload against the scoreboard,
  // and, if out_ready is high, check the handshake returns the block to IDLE.
  task automatic take(input string tag);
    exp_t e;
    int   k;
    bit   seen;
    seen = 1'b0;
    k    = 0;
    while (!seen && k < TMO) begin
      @(posedge sys_clk);
      #1;
      k++;
      if (out_valid) seen = 1'b1;
    end
    chk({tag, "_latency"}, k, DIGITS);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_bin"}, 32'(bin_out), 32'(e.bin));
      chk({tag, "_err"}, 32'(out_err), 32'(e.err));
    end
    if (out_ready && seen) begin
      @(posedge sys_clk);
      #1;
      chk({tag, "_ov_drop"}, 32'(out_valid), 0);
      chk({tag, "_in_ready_back"}, 32'(in_ready), 1);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    acc_cyc   = 0;
    prev_acc  = 0;
    sys_reset = 1'b1;
    in_valid  = 1'b0;
    bcd_in    = '0;
    out_ready = 1'b0;

    #2;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_bin", 32'(bin_out), 0);
    chk("rst_err", 32'(out_err), 0);
    repeat (2) @(posedge sys_clk);
    #1;
    sys_reset = 1'b0;

    // Zero word, then a regular value.
    out_ready = 1'b1;
    send("w0000", 16'h0000, 1'b0);
    chk("w0000_busy", 32'(busy), 1);
    chk("w0000_in_ready_low", 32'(in_ready), 0);
    take("w0000");
    send("w1234", 16'h1234, 1'b0);
    take("w1234");

    // Held result under backpressure; new words ignored while not ready.
    out_ready = 1'b0;
    send("w9999", 16'h9999, 1'b0);
    take("w9999");
    bcd_in   = 16'h0001;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge sys_clk);
      #1;
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_bin", 32'(bin_out), 9999);
      chk("hold_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    out_ready = 1'b0;
    chk("hold_release_idle", 32'(in_ready), 1);
    chk("hold_bin_retained", 32'(bin_out), 9999);
    send("w0001", 16'h0001, 1'b0);
    out_ready = 1'b1;
    take("w0001");

    // Invalid nibble flagged, then cleared by the next word.
    send("w00A0", 16'h00A0, 1'b0);
    take("w00A0");
    send("w0042", 16'h0042, 1'b0);
    take("w0042");

    // Asynchronous reset in the middle of a conversion.
    send("w5678", 16'h5678, 1'b0);
    repeat (2) @(posedge sys_clk);
    #3;
    sys_reset = 1'b1;
    #1;
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_bin", 32'(bin_out), 0);
    chk("arst_err", 32'(out_err), 0);
    junk = sb.pop_front();
    @(posedge sys_clk);
    #1;
    sys_reset = 1'b0;
    send("w0007", 16'h0007, 1'b0);
    take("w0007");

    // Back-to-back stream with in_valid and out_ready held high.
    send("s0001", 16'h0001, 1'b1);
    bcd_in = 16'h0010;
    take("s0001");
    send("s0010", 16'h0010, 1'b1);
    chk("s0010_period", acc_cyc - prev_acc, DIGITS + 2);
    bcd_in = 16'h0100;
    take("s0010");
    send("s0100", 16'h0100, 1'b1);
    chk("s0100_period", acc_cyc - prev_acc, DIGITS + 2);
    bcd_in = 16'h1000;
    take("s0100");
    send("s1000", 16'h1000, 1'b0);
    chk("s1000_period", acc_cyc - prev_acc, DIGITS + 2);
    take("s1000");

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
